// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program counter: next-pc source select
// and the default sequential step.
package pc_pkg;

  localparam int unsigned DEFAULT_STEP = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BRANCH,
    SEL_RET,
    SEL_REDIRECT,
    SEL_RESET
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a top pointer. A simultaneous push and
// pop on a non-empty stack replaces the top entry in place. Pushing into a
// full stack overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic             empty;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;

  assign empty   = (count_q == '0);
  assign ptr_inc = ptr_q + 1'b1;
  assign ptr_dec = ptr_q - 1'b1;

  // Stack storage, pointer, count and sticky overflow update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (push && pop && !empty) begin
      mem_q[ptr_q] <= push_data;
    end else if (push) begin
      mem_q[ptr_inc] <= push_data;
      ptr_q          <= ptr_inc;
      if (count_q == FULL) overflow_q <= 1'b1;
      else                 count_q    <= count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q   <= ptr_dec;
      count_q <= count_q - 1'b1;
    end
  end

  assign top      = empty ? '0 : mem_q[ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/fetch_pc_ras.sv
// Fetch program counter: priority mux over redirect, return, branch and
// sequential sources, with a return-address stack fed by calls.
module fetch_pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       STEP         = DEFAULT_STEP,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               redirect_valid,
  input  logic [WIDTH-1:0]                   redirect_target,
  input  logic                               branch_taken,
  input  logic [WIDTH-1:0]                   branch_target,
  input  logic                               call,
  input  logic                               ret,
  output logic [WIDTH-1:0]                   pc,
  output logic [WIDTH-1:0]                   pc_plus,
  output logic [WIDTH-1:0]                   ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ret_miss,
  output logic                               ras_overflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ret_miss_q;
  logic             ras_empty;
  logic             ras_push, ras_pop;
  pc_sel_e          sel;

  assign pc_plus   = pc_q + WIDTH'(STEP);
  assign ras_empty = (ras_count == '0);

  // Choose the next-pc source by priority.
  always_comb begin
    sel = SEL_SEQ;
    if (reset)                    sel = SEL_RESET;
    else if (redirect_valid)      sel = SEL_REDIRECT;
    else if (!en)                 sel = SEL_HOLD;
    else if (ret && !ras_empty)   sel = SEL_RET;
    else if (ret)                 sel = SEL_SEQ;
    else if (branch_taken)        sel = SEL_BRANCH;
  end

  // An empty-stack return takes no branch, so its call half is dropped too.
  assign ras_push = !reset && !redirect_valid && en && branch_taken && call
                    && (!ret || !ras_empty);
  assign ras_pop  = !reset && !redirect_valid && en && ret && !ras_empty;

  // Next-pc mux.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_RESET:    pc_d = RESET_VECTOR;
      SEL_REDIRECT: pc_d = redirect_target;
      SEL_HOLD:     pc_d = pc_q;
      SEL_RET:      pc_d = ras_top;
      SEL_BRANCH:   pc_d = branch_target;
      SEL_SEQ:      pc_d = pc_plus;
      default:      pc_d = pc_q;
    endcase
  end

  // PC register and the registered return-miss pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      ret_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ret_miss_q <= !redirect_valid && en && ret && ras_empty;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow)
  );

  assign pc       = pc_q;
  assign ret_miss = ret_miss_q;

endmodule

// File: tb/tb_fetch_pc_ras.sv
module tb_fetch_pc_ras;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset, en, redirect_valid, branch_taken, call, ret;
  logic [W-1:0] redirect_target, branch_target;
  logic [W-1:0] pc, pc_plus, ras_top;
  logic [2:0]   ras_count;
  logic         ret_miss, ras_overflow;

  int tests = 0;
  int fails = 0;

  fetch_pc_ras #(
    .WIDTH        (W),
    .RESET_VECTOR (64'h1000),
    .STEP         (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .pc_plus         (pc_plus),
    .ras_top         (ras_top),
    .ras_count       (ras_count),
    .ret_miss        (ret_miss),
    .ras_overflow    (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; en = 1; redirect_valid = 0; redirect_target = '0;
    branch_taken = 0; branch_target = '0; call = 0; ret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [W-1:0] a);
    idle(); redirect_valid = 1; redirect_target = a; tick(); idle();
  endtask

  task automatic do_call(input logic [W-1:0] tgt);
    idle(); branch_taken = 1; call = 1; branch_target = tgt; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); tick(); idle();
    tests++; if (pc !== 64'h1000) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 64'h1000); end
    tests++; if (ras_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", ras_count); end
    tests++; if (ras_top !== 64'h0) begin fails++; $display("FAIL reset_top got %h want 0", ras_top); end
    tests++; if (ret_miss !== 1'b0 || ras_overflow !== 1'b0) begin fails++;
      $display("FAIL reset_flags got miss=%b ovf=%b want 0 0", ret_miss, ras_overflow); end
    tests++; if (pc_plus !== 64'h1004) begin fails++; $display("FAIL reset_pc_plus got %h want %h", pc_plus, 64'h1004); end
  endtask

  task automatic test_seq_stall();
    logic [W-1:0] exp [3] = '{64'h1004, 64'h1008, 64'h100C};
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      tests++; if (pc !== exp[i]) begin fails++; $display("FAIL seq_%0d got %h want %h", i, pc, exp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      idle(); en = 0; branch_taken = 1; branch_target = 64'h9999; tick();
      tests++; if (pc !== 64'h100C) begin fails++; $display("FAIL stall_%0d got %h want %h", i, pc, 64'h100C); end
    end
    idle();
  endtask

  task automatic test_call_ret();
    go_to(64'h2000);
    do_call(64'h3000);
    tests++; if (pc !== 64'h3000) begin fails++; $display("FAIL call_pc got %h want %h", pc, 64'h3000); end
    tests++; if (ras_top !== 64'h2004) begin fails++; $display("FAIL call_top got %h want %h", ras_top, 64'h2004); end
    tests++; if (ras_count !== 3'd1) begin fails++; $display("FAIL call_count got %0d want 1", ras_count); end
    // call without branch_taken must not push
    idle(); call = 1; tick(); idle();
    tests++; if (ras_count !== 3'd1 || pc !== 64'h3004) begin fails++;
      $display("FAIL call_no_branch got cnt=%0d pc=%h want 1 %h", ras_count, pc, 64'h3004); end
    idle(); ret = 1; tick(); idle();
    tests++; if (pc !== 64'h2004) begin fails++; $display("FAIL ret_pc got %h want %h", pc, 64'h2004); end
    tests++; if (ras_count !== 3'd0 || ras_top !== 64'h0) begin fails++;
      $display("FAIL ret_count got cnt=%0d top=%h want 0 0", ras_count, ras_top); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp [4] = '{64'h54, 64'h44, 64'h34, 64'h24};
    for (int i = 1; i <= 5; i++) begin
      go_to(W'(i * 16));
      do_call(64'h900);
    end
    tests++; if (ras_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", ras_overflow); end
    tests++; if (ras_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", ras_count); end
    for (int i = 0; i < 4; i++) begin
      idle(); ret = 1; tick(); idle();
      tests++; if (pc !== exp[i]) begin fails++; $display("FAIL ovf_ret_%0d got %h want %h", i, pc, exp[i]); end
      tests++; if (ret_miss !== 1'b0) begin fails++; $display("FAIL ovf_nomiss_%0d got %b want 0", i, ret_miss); end
    end
    idle(); ret = 1; tick(); idle();
    tests++; if (pc !== 64'h28) begin fails++; $display("FAIL miss_pc got %h want %h", pc, 64'h28); end
    tests++; if (ret_miss !== 1'b1) begin fails++; $display("FAIL miss_pulse got %b want 1", ret_miss); end
    tick();
    tests++; if (ret_miss !== 1'b0) begin fails++; $display("FAIL miss_one_cycle got %b want 0", ret_miss); end
    tests++; if (ras_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", ras_overflow); end
  endtask

  task automatic test_redirect();
    go_to(64'h600);
    do_call(64'h610);
    idle(); en = 0; ret = 1; redirect_valid = 1; redirect_target = 64'h8000; tick(); idle();
    tests++; if (pc !== 64'h8000) begin fails++; $display("FAIL redir_pc got %h want %h", pc, 64'h8000); end
    tests++; if (ras_count !== 3'd1 || ras_top !== 64'h604) begin fails++;
      $display("FAIL redir_ras got cnt=%0d top=%h want 1 %h", ras_count, ras_top, 64'h604); end
  endtask

  task automatic test_wrap();
    go_to(64'hFFFF_FFFF_FFFF_FFFC);
    tests++; if (pc_plus !== 64'h0) begin fails++; $display("FAIL wrap_plus got %h want 0", pc_plus); end
    idle(); tick();
    tests++; if (pc !== 64'h0) begin fails++; $display("FAIL wrap_pc got %h want 0", pc); end
  endtask

  task automatic test_back_to_back();
    go_to(64'h4FC);
    do_call(64'h700);
    tests++; if (ras_top !== 64'h500 || ras_count !== 3'd2) begin fails++;
      $display("FAIL b2b_setup got top=%h cnt=%0d want %h 2", ras_top, ras_count, 64'h500); end
    idle(); ret = 1; call = 1; branch_taken = 1; branch_target = 64'h999; tick(); idle();
    tests++; if (pc !== 64'h500) begin fails++; $display("FAIL b2b_pc got %h want %h", pc, 64'h500); end
    tests++; if (ras_top !== 64'h704) begin fails++; $display("FAIL b2b_top got %h want %h", ras_top, 64'h704); end
    tests++; if (ras_count !== 3'd2) begin fails++; $display("FAIL b2b_count got %0d want 2", ras_count); end
  endtask

  task automatic test_reset_mid();
    idle(); reset = 1; ret = 1; call = 1; branch_taken = 1; branch_target = 64'h777;
    redirect_valid = 1; redirect_target = 64'h888; tick(); idle();
    tests++; if (pc !== 64'h1000 || ras_count !== 3'd0 || ras_top !== 64'h0 || ras_overflow !== 1'b0) begin fails++;
      $display("FAIL reset_mid got pc=%h cnt=%0d top=%h ovf=%b want 1000 0 0 0", pc, ras_count, ras_top, ras_overflow); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_seq_stall();
    test_call_ret();
    test_overflow();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ras.md
# fetch_pc_ras

Parametrised fetch program counter with a built-in return-address stack (RAS). It holds the current fetch address, chooses the next address each cycle from redirect, return, branch or sequential sources, and supports stalls. Calls push their return address into the RAS; returns pop it as their target. It sits at the front of the pipeline, feeding instruction memory, and takes redirect, branch and stall controls from the decode and execute stages.

## Interface
- WIDTH, 64: address width in bits.
- RESET_VECTOR, 0: value of pc after reset.
- STEP, 4: sequential increment in bytes.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two and at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  advance enable; 0 means stall.
- redirect_valid  in  1  flush or exception redirect.
- redirect_target  in  WIDTH  redirect address.
- branch_taken  in  1  taken branch or call.
- branch_target  in  WIDTH  branch address.
- call  in  1  push pc+STEP; qualified by branch_taken.
- ret  in  1  pop the RAS and jump to the popped value.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus  out  WIDTH  pc+STEP (combinational).
- ras_top  out  WIDTH  top RAS entry (combinational); 0 when empty.
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid entries (registered).
- ret_miss  out  1  one-cycle pulse: a ret was executed with an empty RAS.
- ras_overflow  out  1  sticky flag: a push occurred while the RAS was full.

## Operation
- Next-pc priority, highest first:
  1. reset: pc = RESET_VECTOR.
  2. redirect_valid: pc = redirect_target. This applies even when en=0. RAS is unchanged; call and ret are ignored.
  3. en=0: pc holds; RAS holds; all commands are ignored.
  4. ret with ras_count>0: pc = ras_top, then pop.
  5. ret with ras_count==0: pc = pc+STEP; ret_miss=1 on the next cycle.
  6. branch_taken: pc = branch_target. If call=1, also push pc+STEP.
  7. Otherwise: pc = pc+STEP.
- ret and branch_taken together: ret wins and the branch is ignored.
- call without branch_taken is ignored.
- ret and call+branch_taken together with a non-empty RAS: pc = ras_top. The top entry is replaced in place by pc+STEP; ras_count is unchanged.
- RAS is circular with a top pointer.
  - Push when full: overwrite the oldest entry, ras_count stays at RAS_DEPTH, ras_overflow is set.
  - Pop: decrement the pointer and the count.
- Arithmetic is modulo 2^WIDTH. Carry is discarded, so pc = 2^WIDTH−STEP advances to 0.
- Reset values: pc=RESET_VECTOR, ras_count=0, ret_miss=0, ras_overflow=0, and all RAS entries = 0.
- Reset asserted mid-sequence overrides every command in that cycle.

## Timing
- One-cycle latency: inputs sampled at edge N take effect in pc after edge N.
- pc_plus and ras_top follow pc and the RAS state combinationally within the same cycle.
- ret_miss is registered and high for exactly one cycle.
- ras_overflow stays high until reset.
- No handshake. Stall is level-sensitive; pc is stable for as long as en=0 and redirect_valid=0.

## Structure
- Shared package pc_pkg holds:
  - the next-pc select enum: SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_RET, SEL_REDIRECT, SEL_RESET;
  - the default STEP constant.
- One sub-module, ras_stack:
  - parameters WIDTH and DEPTH;
  - inputs push, pop, push_data;
  - outputs top, count, overflow;
  - implements the simultaneous push+pop replace-top rule.
- The top level holds the pc register, the priority mux and the adder.

## Test plan
Defaults for all scenarios: WIDTH=64, STEP=4, RAS_DEPTH=4, RESET_VECTOR=0x1000.
- Reset, then en=1 for 3 cycles: pc goes 0x1000 → 0x1004 → 0x1008 → 0x100C. Hold en=0 for 2 cycles: pc stays 0x100C.
- At pc=0x2000, call+branch_taken to 0x3000: pc=0x3000, ras_top=0x2004, ras_count=1. Then ret: pc=0x2004, ras_count=0.
- Five calls from 0x10, 0x20, 0x30, 0x40, 0x50: ras_overflow=1 and ras_count=4. Four rets return 0x54, 0x44, 0x34, 0x24. A fifth ret gives ret_miss=1 and pc = previous pc+4.
- redirect_valid with target 0x8000 while en=0 and ret=1: pc=0x8000; ras_count unchanged.
- pc=0xFFFF_FFFF_FFFF_FFFC with en=1: next pc is 0; pc_plus shows 0 beforehand.
- ret and call+branch_taken in the same cycle with ras_top=0x500 at pc=0x700: pc=0x500, ras_top=0x704, ras_count unchanged.
